// File: rtl/i3c_csr_req_bridge.sv
// i3c_csr_req_bridge: registers AHB component requests toward the I3C
// CSR cpuif, derives write byte-enables, waits for acks with a timeout.
module i3c_csr_req_bridge #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      hclk_i,
  input  logic                      hreset_n_i,
  input  logic                      dv_i,
  input  logic                      write_i,
  input  logic [AHB_ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]                size_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      hld_o,
  output logic                      err_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      cpuif_req_o,
  output logic                      cpuif_req_is_wr_o,
  output logic [CSR_ADDR_WIDTH-1:0] cpuif_addr_o,
  output logic [DATA_WIDTH-1:0]     cpuif_wr_data_o,
  output logic [DATA_WIDTH-1:0]     cpuif_wr_biten_o,
  input  logic                      cpuif_req_stall_wr_i,
  input  logic                      cpuif_req_stall_rd_i,
  input  logic                      cpuif_rd_ack_i,
  input  logic                      cpuif_rd_err_i,
  input  logic [DATA_WIDTH-1:0]     cpuif_rd_data_i,
  input  logic                      cpuif_wr_ack_i,
  input  logic                      cpuif_wr_err_i
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("i3c_csr_req_bridge: only DATA_WIDTH=32 is supported");
  end

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic                      wr_q, wr_d;
  logic [CSR_ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     biten_q, biten_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

  logic                      req;
  logic                      stall;
  logic                      ack;
  logic                      ack_err;
  logic                      illegal;
  logic [DATA_WIDTH-1:0]     be;

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[AHB_ADDR_WIDTH-1:CSR_ADDR_WIDTH];

  assign stall   = wr_q ? cpuif_req_stall_wr_i : cpuif_req_stall_rd_i;
  assign ack     = wr_q ? cpuif_wr_ack_i : cpuif_rd_ack_i;
  assign ack_err = wr_q ? cpuif_wr_err_i : cpuif_rd_err_i;

  assign illegal = (size_i > 3'd2) ||
                   ((size_i == 3'd1) && addr_i[0]);

  always_comb begin
    be = '0;
    unique case (size_i)
      3'd0:    be = DATA_WIDTH'(8'hFF) << {addr_i[1:0], 3'b000};
      3'd1:    be = DATA_WIDTH'(16'hFFFF) << {addr_i[1], 4'b0000};
      default: be = '1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    biten_d = biten_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rdata_d = '0;
    req     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dv_i) begin
          wr_d    = write_i;
          addr_d  = addr_i[CSR_ADDR_WIDTH-1:2];
          wdata_d = wdata_i;
          biten_d = write_i ? be : '0;
          if (illegal) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (!stall) begin
          req = 1'b1;
          if (ack) begin
            state_d = S_DONE;
            err_d   = ack_err;
            rdata_d = (!wr_q && !ack_err) ? cpuif_rd_data_i : '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (ack) begin
          state_d = S_DONE;
          err_d   = ack_err;
          rdata_d = (!wr_q && !ack_err) ? cpuif_rd_data_i : '0;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      biten_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      biten_q <= biten_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset gating keeps the stall low while the block is held in reset.
  assign hld_o = dv_i & hreset_n_i & (state_q != S_DONE);

  assign err_o             = err_q;
  assign rdata_o           = rdata_q;
  assign cpuif_req_o       = req;
  assign cpuif_req_is_wr_o = wr_q;
  assign cpuif_addr_o      = {addr_q, 2'b00};
  assign cpuif_wr_data_o   = wdata_q;
  assign cpuif_wr_biten_o  = biten_q;

endmodule

// File: tb/tb_i3c_csr_req_bridge.sv
// tb_i3c_csr_req_bridge: directed plus randomized transactions checked
// against a cycle-level transaction model of the request bridge.
module tb_i3c_csr_req_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv, wr;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [31:0] wdata;
  logic        hld, err;
  logic [31:0] rdata;
  logic        req, req_wr;
  logic [11:0] caddr;
  logic [31:0] cwdata, cbiten;
  logic        stall_wr, stall_rd;
  logic        rd_ack, rd_err, wr_ack, wr_err;
  logic [31:0] rd_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i3c_csr_req_bridge #(
    .AHB_ADDR_WIDTH(32),
    .CSR_ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .hclk_i(clk),
    .hreset_n_i(rst_n),
    .dv_i(dv),
    .write_i(wr),
    .addr_i(addr),
    .size_i(size),
    .wdata_i(wdata),
    .hld_o(hld),
    .err_o(err),
    .rdata_o(rdata),
    .cpuif_req_o(req),
    .cpuif_req_is_wr_o(req_wr),
    .cpuif_addr_o(caddr),
    .cpuif_wr_data_o(cwdata),
    .cpuif_wr_biten_o(cbiten),
    .cpuif_req_stall_wr_i(stall_wr),
    .cpuif_req_stall_rd_i(stall_rd),
    .cpuif_rd_ack_i(rd_ack),
    .cpuif_rd_err_i(rd_err),
    .cpuif_rd_data_i(rd_data),
    .cpuif_wr_ack_i(wr_ack),
    .cpuif_wr_err_i(wr_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_biten(input bit w,
                                              input logic [31:0] a,
                                              input logic [2:0] s);
    logic [31:0] r;
    int nb, first;
    r = '0;
    if (!w) return r;
    nb = 1 << s;
    first = (int'(a[1:0]) / nb) * nb;
    for (int j = 0; j < 4; j++)
      if (j >= first && j < first + nb) r[8*j +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic quiet_inputs();
    dv = 0; wr = 0; addr = '0; size = '0; wdata = '0;
    stall_wr = 0; stall_rd = 0;
    rd_ack = 0; rd_err = 0; wr_ack = 0; wr_err = 0;
    rd_data = '0;
  endtask

  task automatic txn(input bit w, input logic [31:0] a,
                     input logic [2:0] s, input logic [31:0] wd,
                     input int stall_n, input int ack_dly,
                     input bit ack_e, input logic [31:0] rd,
                     input bit noack);
    bit illegal;
    int issue, done, ack_c;
    logic [31:0] e_err, e_rd, e_be;
    illegal = (s > 2) || (s == 1 && a[0]);
    e_be = model_biten(w, a, s);
    if (illegal) begin
      issue = -1; ack_c = -1; done = 1; e_err = 1; e_rd = 0;
    end else begin
      issue = 1 + stall_n;
      if (!noack && ack_dly <= TO) begin
        ack_c = issue + ack_dly;
        done  = ack_c + 1;
        e_err = 32'(ack_e);
        e_rd  = (!w && !ack_e) ? rd : 32'h0;
      end else begin
        ack_c = -1;
        done  = issue + TO + 1;
        e_err = 1;
        e_rd  = 0;
      end
    end
    for (int c = 0; c <= done; c++) begin
      @(posedge clk); #1;
      dv = 1; wr = w; addr = a; size = s; wdata = wd;
      if (w) begin
        stall_wr = !illegal && c >= 1 && c <= stall_n;
        stall_rd = 1'($urandom);
        wr_ack   = (c == ack_c);
        wr_err   = (c == ack_c) ? ack_e : 1'($urandom);
        rd_ack   = 1'($urandom);
        rd_err   = 1'($urandom);
        rd_data  = $urandom;
      end else begin
        stall_rd = !illegal && c >= 1 && c <= stall_n;
        stall_wr = 1'($urandom);
        rd_ack   = (c == ack_c);
        rd_err   = (c == ack_c) ? ack_e : 1'($urandom);
        rd_data  = (c == ack_c) ? rd : $urandom;
        wr_ack   = 1'($urandom);
        wr_err   = 1'($urandom);
      end
      @(negedge clk);
      chk("hld", 32'(hld), 32'(c != done));
      chk("req", 32'(req), 32'(c == issue));
      if (c == issue) begin
        chk("req_wr", 32'(req_wr), 32'(w));
        chk("addr", 32'(caddr), {20'h0, a[11:2], 2'b00});
        chk("biten", cbiten, e_be);
        if (w) chk("wdata", cwdata, wd);
      end
      chk("err", 32'(err), (c == done) ? e_err : 32'h0);
      chk("rdata", rdata, (c == done) ? e_rd : 32'h0);
    end
    @(posedge clk); #1;
    quiet_inputs();
    @(negedge clk);
    chk("idle_hld", 32'(hld), 0);
    chk("idle_req", 32'(req), 0);
  endtask

  initial begin
    bit rw;
    logic [31:0] ra;
    logic [2:0] rs;
    quiet_inputs();
    rst_n = 0;
    dv = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hld", 32'(hld), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_biten", cbiten, 0);
    @(posedge clk); #1;
    rst_n = 1;
    dv = 0;
    @(negedge clk);
    chk("idle_hld0", 32'(hld), 0);

    txn(1, 32'h104, 2, 32'hA5A5_0001, 0, 0, 0, 0, 0);
    txn(1, 32'h0103, 0, 32'h1122_3344, 0, 0, 0, 0, 0);
    txn(1, 32'h102, 1, 32'h5566_7788, 0, 1, 0, 0, 0);
    txn(1, 32'h101, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    txn(0, 32'h200, 2, 32'h0, 3, 2, 0, 32'h1234_5678, 0);
    txn(0, 32'h300, 2, 32'h0, 0, 0, 0, 32'h0, 1);

    @(posedge clk); #1;
    rd_ack = 1; rd_err = 1; rd_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_hld", 32'(hld), 0);
    chk("late_req", 32'(req), 0);
    @(posedge clk); #1;
    quiet_inputs();
    @(negedge clk);
    chk("late_err", 32'(err), 0);
    chk("late_rdata", rdata, 0);

    txn(1, 32'h304, 2, 32'hCAFE_F00D, 0, 1, 0, 0, 0);
    txn(1, 32'h008, 2, 32'h0BAD_0BAD, 0, 1, 1, 0, 0);
    txn(0, 32'h00C, 2, 32'h0, 0, 0, 1, 32'h7777_7777, 0);

    @(posedge clk); #1;
    dv = 1; wr = 1; addr = 32'h40; size = 2; wdata = 32'h9999_AAAA;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    chk("rstw_hld", 32'(hld), 0);
    chk("rstw_req", 32'(req), 0);
    chk("rstw_wr", 32'(req_wr), 0);
    chk("rstw_addr", 32'(caddr), 0);
    chk("rstw_wdata", cwdata, 0);
    chk("rstw_biten", cbiten, 0);
    chk("rstw_err", 32'(err), 0);
    @(posedge clk); #1;
    rst_n = 1;
    quiet_inputs();
    @(negedge clk);
    chk("rstw_idle", 32'(hld), 0);
    txn(0, 32'h44, 2, 32'h0, 0, 1, 0, 32'h0F0F_1234, 0);

    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom);
      ra = $urandom;
      rs = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) rs = 3'($urandom_range(0, 2));
      if (rs == 1 && $urandom_range(0, 3) != 0) ra[0] = 1'b0;
      txn(rw, ra, rs, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 9),
          ($urandom_range(0, 3) == 0), $urandom,
          ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i3c_csr_req_bridge.md
Name: i3c_csr_req_bridge

Overview:
- Request stage between the AHB-Lite subordinate's component interface (dv/hld/err/write/addr/wdata/rdata) and the I3C CSR block's cpuif (req/stall/ack/err).
- Registers each request and derives write byte-enables from transfer size and address.
- Holds the AHB side until the CSR block acks, and bounds every access with a timeout.
- Replaces the direct wiring that ties write byte-enables to all-ones and ignores acks.

Parameters:
- AHB_ADDR_WIDTH, 32, width of upstream byte address.
- CSR_ADDR_WIDTH, 12, width of cpuif byte address; taken from the low bits of addr_i.
- DATA_WIDTH, 32, data width; only 32 supported; any other value triggers $error at elaboration.
- TIMEOUT_CYCLES, 256, WAIT-state cycle limit before error completion; 0 disables the timeout.

Ports:
- hclk_i  in  1  clock
- hreset_n_i  in  1  asynchronous active-low reset
- dv_i  in  1  upstream request valid; fields held stable while hld_o=1
- write_i  in  1  1=write, 0=read
- addr_i  in  AHB_ADDR_WIDTH  byte address
- size_i  in  3  AHB hsize of the transfer
- wdata_i  in  DATA_WIDTH  write data
- hld_o  out  1  stall to upstream
- err_o  out  1  completion error, valid in the completion cycle
- rdata_o  out  DATA_WIDTH  read data, valid in the completion cycle
- cpuif_req_o  out  1  CSR request, single-cycle pulse
- cpuif_req_is_wr_o  out  1  CSR write flag
- cpuif_addr_o  out  CSR_ADDR_WIDTH  word-aligned address, low 2 bits forced to 0
- cpuif_wr_data_o  out  DATA_WIDTH  write data
- cpuif_wr_biten_o  out  DATA_WIDTH  bit enables
- cpuif_req_stall_wr_i / cpuif_req_stall_rd_i  in  1 each  CSR stall inputs
- cpuif_rd_ack_i, cpuif_rd_err_i  in  1 each  read ack and read error
- cpuif_rd_data_i  in  DATA_WIDTH  read data
- cpuif_wr_ack_i, cpuif_wr_err_i  in  1 each  write ack and write error

Behaviour:
- Reset (async, hreset_n_i=0):
  - state=IDLE, timeout counter=0.
  - All outputs 0; any in-flight request is dropped.
- hld_o = dv_i & (state != DONE), combinational.
- A request completes in the cycle where dv_i=1 and hld_o=0, i.e. state DONE; err_o and rdata_o are registered and valid only in DONE, 0 elsewhere.
- IDLE, dv_i=1:
  - Capture write/addr/wdata; compute biten.
  - Illegal request: go to DONE with err=1, no cpuif request. Illegal means size_i>2, or size_i=1 with addr_i[0]=1.
  - Legal request: go to REQ.
- biten for legal requests:
  - size 0: 0xFF << 8*addr[1:0].
  - size 1: 0xFFFF << 16*addr[1].
  - size 2: all ones.
  - Reads: biten = 0.
- REQ:
  - cpuif_req_o=1 with captured fields, only while the relevant stall (wr or rd) is 0.
  - Stall=1: remain in REQ with req_o=0.
  - Issued and matching ack seen in the same cycle: go to DONE.
  - Issued without ack: go to WAIT, counter cleared.
- WAIT:
  - Matching ack (wr_ack for writes, rd_ack for reads): go to DONE; err = the corresponding *_err; rdata = cpuif_rd_data_i on reads, 0 on writes and on error.
  - Counter increments each cycle. When counter = TIMEOUT_CYCLES-1 and no ack: go to DONE with err=1, rdata=0.
- DONE: unconditionally returns to IDLE next cycle. A dv_i in the following cycle is treated as a new request.
- Acks or errors arriving in IDLE, or in REQ before issue, are ignored. A non-matching ack type in WAIT is ignored.
- Minimum latency, dv_i rising at cycle 0:
  - cpuif_req_o at cycle 1.
  - Zero-wait ack at cycle 1 gives completion at cycle 2.
  - hld_o=1 in cycles 0-1.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- Only one outstanding request; no pipelining of a second dv_i before DONE.

Test Plan:
- Word write, addr=0x104, size=2, wdata=0xA5A5_0001, wr_ack in the req cycle:
  - cpuif_req_o one cycle with addr=0x104, biten=0xFFFF_FFFF.
  - Completion at cycle 2, err_o=0.
- Byte write, addr=0x0103, size=0: biten=0xFF00_0000, cpuif_addr_o=0x100.
- Halfword write, addr=0x102, size=1: biten=0xFFFF_0000.
- Halfword write, addr=0x101: err_o=1 at cycle 1, no cpuif_req_o.
- Read with stall_rd=1 for 3 cycles, then rd_ack with rd_data=0x1234_5678 two cycles after issue:
  - hld_o held throughout.
  - rdata_o=0x1234_5678, err_o=0.
  - Single req pulse, issued only after stall drops.
- Read with TIMEOUT_CYCLES=8 and no ack:
  - DONE exactly 8 cycles after entering WAIT, err_o=1, rdata_o=0.
  - A late rd_ack while IDLE is ignored.
  - A subsequent write completes normally.
- wr_ack with wr_err=1: err_o=1.
- Reset asserted in WAIT:
  - All outputs 0 immediately, state IDLE.
  - After release, a new read completes normally.
